// File: rtl/opb_arb_pkg.sv
// Shared definitions for the two-master OPB arbiter: FSM encoding and the
// default number of unanswered WAIT cycles before an error is forced.
package opb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/opb_rr_pick2.sv
// Two-way round-robin picker: the pointer names the favoured master, which
// wins whenever it requests; otherwise the other requester wins.
module opb_rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (req[ptr]) begin
      win[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      win[~ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/opb_dual_master_arb.sv
// Two-master OPB arbiter driving a single slave-side bus, with retry, error,
// burst continuation and a suppressible response timeout.
module opb_dual_master_arb
  import opb_arb_pkg::*;
#(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter int C_TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  input  logic [1:0]                  M_request,
  input  logic [2*C_OPB_AWIDTH-1:0]   M_ABus,
  input  logic [2*C_OPB_DWIDTH/8-1:0] M_BE,
  input  logic [2*C_OPB_DWIDTH-1:0]   M_DBus,
  input  logic [1:0]                  M_RNW,
  input  logic [1:0]                  M_seqAddr,
  output logic [1:0]                  M_grant,
  output logic [1:0]                  M_xferAck,
  output logic [1:0]                  M_errAck,
  output logic [1:0]                  M_retry,
  output logic [C_OPB_DWIDTH-1:0]     M_rdDBus,
  output logic [C_OPB_AWIDTH-1:0]     OPB_ABus,
  output logic [C_OPB_DWIDTH/8-1:0]   OPB_BE,
  output logic [C_OPB_DWIDTH-1:0]     OPB_DBus,
  output logic                        OPB_RNW,
  output logic                        OPB_select,
  output logic                        OPB_seqAddr,
  input  logic [C_OPB_DWIDTH-1:0]     Sl_DBus,
  input  logic                        Sl_xferAck,
  input  logic                        Sl_errAck,
  input  logic                        Sl_retry,
  input  logic                        Sl_toutSup,
  output arb_state_t                  dbg_state
);

  localparam int AW = C_OPB_AWIDTH;
  localparam int DW = C_OPB_DWIDTH;
  localparam int BW = C_OPB_DWIDTH / 8;
  localparam int CW = $clog2(C_TIMEOUT + 1);

  // Handshake: a master holds M_request until it sees exactly one of
  // xferAck/errAck/retry; dropping it while waiting abandons the transfer.
  arb_state_t    state;
  logic          rst_done;
  logic          ptr;
  logic          win_idx;
  logic          upd_ptr;
  logic [CW-1:0] cnt;
  logic [1:0]    pick;

  logic          ld_idx;
  logic [AW-1:0] ld_abus;
  logic [BW-1:0] ld_be;
  logic [DW-1:0] ld_dbus;
  logic          ld_rnw;
  logic          ld_seq;

  opb_rr_pick2 u_pick (
    .req (M_request),
    .ptr (ptr),
    .win (pick)
  );

  // Fields of the master about to be presented: the fresh winner from IDLE,
  // or the current owner when a burst continues.
  always_comb begin
    ld_idx  = (state == ST_IDLE) ? pick[1] : win_idx;
    ld_abus = ld_idx ? M_ABus[2*AW-1:AW] : M_ABus[AW-1:0];
    ld_be   = ld_idx ? M_BE[2*BW-1:BW]   : M_BE[BW-1:0];
    ld_dbus = ld_idx ? M_DBus[2*DW-1:DW] : M_DBus[DW-1:0];
    ld_rnw  = M_RNW[ld_idx];
    ld_seq  = M_seqAddr[ld_idx];
  end

  assign dbg_state = state;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state       <= ST_IDLE;
      rst_done    <= 1'b0;
      ptr         <= 1'b0;
      win_idx     <= 1'b0;
      upd_ptr     <= 1'b0;
      cnt         <= '0;
      M_grant     <= '0;
      M_xferAck   <= '0;
      M_errAck    <= '0;
      M_retry     <= '0;
      M_rdDBus    <= '0;
      OPB_ABus    <= '0;
      OPB_BE      <= '0;
      OPB_DBus    <= '0;
      OPB_RNW     <= 1'b0;
      OPB_select  <= 1'b0;
      OPB_seqAddr <= 1'b0;
    end else begin
      rst_done  <= 1'b1;
      M_xferAck <= '0;
      M_errAck  <= '0;
      M_retry   <= '0;
      case (state)
        ST_IDLE: begin
          // rst_done holds off arbitration for the first cycle out of reset.
          if (rst_done && (|M_request)) begin
            state       <= ST_ADDR;
            win_idx     <= pick[1];
            M_grant     <= pick;
            OPB_select  <= 1'b1;
            OPB_ABus    <= ld_abus;
            OPB_BE      <= ld_be;
            OPB_DBus    <= ld_dbus;
            OPB_RNW     <= ld_rnw;
            OPB_seqAddr <= ld_seq;
          end
        end
        ST_ADDR: begin
          state <= ST_WAIT;
          cnt   <= '0;
        end
        ST_WAIT: begin
          if (Sl_retry || Sl_errAck || Sl_xferAck || !M_request[win_idx] ||
              (!Sl_toutSup && cnt == CW'(C_TIMEOUT - 1))) begin
            if (Sl_retry) begin
              M_retry[win_idx] <= 1'b1;
            end else if (Sl_errAck) begin
              M_errAck[win_idx] <= 1'b1;
              upd_ptr           <= 1'b1;
            end else if (Sl_xferAck) begin
              M_xferAck[win_idx] <= 1'b1;
              upd_ptr            <= 1'b1;
              if (OPB_RNW) begin
                M_rdDBus <= Sl_DBus;
              end
            end else if (M_request[win_idx]) begin
              // Timeout: request still held but the slave never answered.
              M_errAck[win_idx] <= 1'b1;
              upd_ptr           <= 1'b1;
            end
            if (!Sl_retry && !Sl_errAck && Sl_xferAck &&
                M_seqAddr[win_idx] && M_request[win_idx]) begin
              state       <= ST_ADDR;
              upd_ptr     <= 1'b0;
              OPB_ABus    <= ld_abus;
              OPB_BE      <= ld_be;
              OPB_DBus    <= ld_dbus;
              OPB_RNW     <= ld_rnw;
              OPB_seqAddr <= ld_seq;
            end else begin
              state       <= ST_DONE;
              M_grant     <= '0;
              OPB_select  <= 1'b0;
              OPB_ABus    <= '0;
              OPB_BE      <= '0;
              OPB_DBus    <= '0;
              OPB_RNW     <= 1'b0;
              OPB_seqAddr <= 1'b0;
            end
          end else if (!Sl_toutSup) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (upd_ptr) begin
            ptr <= ~win_idx;
          end
          upd_ptr <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opb_dual_master_arb.sv
// Directed bench for opb_dual_master_arb: single reads, alternation, timeout,
// retry, bursts and asynchronous reset in the middle of a transfer.
module tb_opb_dual_master_arb;
  import opb_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  m_request = '0;
  logic [63:0] m_abus = '0;
  logic [7:0]  m_be = '0;
  logic [63:0] m_dbus = '0;
  logic [1:0]  m_rnw = '0;
  logic [1:0]  m_seqaddr = '0;
  logic [1:0]  m_grant, m_xferack, m_errack, m_retry;
  logic [31:0] m_rddbus, opb_abus, opb_dbus;
  logic [3:0]  opb_be;
  logic        opb_rnw, opb_select, opb_seqaddr;
  logic [31:0] sl_dbus = '0;
  logic        sl_xferack = 1'b0, sl_errack = 1'b0, sl_retry = 1'b0, sl_toutsup = 1'b0;
  arb_state_t  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  opb_dual_master_arb dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n),
    .M_request(m_request), .M_ABus(m_abus), .M_BE(m_be), .M_DBus(m_dbus),
    .M_RNW(m_rnw), .M_seqAddr(m_seqaddr),
    .M_grant(m_grant), .M_xferAck(m_xferack), .M_errAck(m_errack),
    .M_retry(m_retry), .M_rdDBus(m_rddbus),
    .OPB_ABus(opb_abus), .OPB_BE(opb_be), .OPB_DBus(opb_dbus),
    .OPB_RNW(opb_rnw), .OPB_select(opb_select), .OPB_seqAddr(opb_seqaddr),
    .Sl_DBus(sl_dbus), .Sl_xferAck(sl_xferack), .Sl_errAck(sl_errack),
    .Sl_retry(sl_retry), .Sl_toutSup(sl_toutsup),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_master(input int m, input logic [31:0] addr, input logic rnw,
                            input logic seq, input logic req);
    m_abus[m*32 +: 32] = addr;
    m_dbus[m*32 +: 32] = addr ^ 32'h5A5A_0000;
    m_be[m*4 +: 4]     = 4'hF;
    m_rnw[m]           = rnw;
    m_seqaddr[m]       = seq;
    m_request[m]       = req;
  endtask

  // Returns at the first tick where a grant is visible (the ADDR cycle).
  task automatic wait_grant(input string tag, output logic [1:0] g);
    logic found;
    found = 1'b0;
    g = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (m_grant != 2'b00) begin
        found = 1'b1;
        g = m_grant;
      end
    end
    check(tag, found, 1'b1);
  endtask

  // From the ADDR cycle: ack in the first WAIT cycle, return on the pulse cycle.
  task automatic ack_now(input logic [31:0] data);
    tick();
    sl_xferack = 1'b1;
    sl_dbus    = data;
    tick();
    sl_xferack = 1'b0;
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] prev;
    int n;
    logic err_seen;
    int acks;

    // reset state
    repeat (3) tick();
    check("rst_grant", m_grant, 2'b00);
    check("rst_select", opb_select, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_rddbus", m_rddbus, 32'h0);

    // master 0 read, first grant two cycles after release, ack in WAIT cycle 3
    rst_n = 1'b1;
    set_master(0, 32'h0000_0010, 1'b1, 1'b0, 1'b1);
    tick();
    check("grant_early", m_grant, 2'b00);
    tick();
    check("rd_grant", m_grant, 2'b01);
    check("rd_select", opb_select, 1'b1);
    check("rd_abus", opb_abus, 32'h0000_0010);
    check("rd_rnw", opb_rnw, 1'b1);
    check("rd_be", opb_be, 4'hF);
    tick();
    tick();
    tick();
    sl_xferack = 1'b1;
    sl_dbus    = 32'hB00B_0100;
    tick();
    sl_xferack = 1'b0;
    m_request  = '0;
    check("rd_xferack", m_xferack, 2'b01);
    check("rd_data", m_rddbus, 32'hB00B_0100);
    check("rd_sel_low", opb_select, 1'b0);
    check("rd_abus_zero", opb_abus, 32'h0);
    check("rd_grant_low", m_grant, 2'b00);
    tick();
    check("rd_ack_single", m_xferack, 2'b00);

    // timeout: silent slave, errAck decided in the 16th WAIT cycle
    set_master(0, 32'h0000_0020, 1'b1, 1'b0, 1'b1);
    wait_grant("to_grant_wait", g);
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      tick();
      if (m_errack != 2'b00) n = i;
    end
    m_request = '0;
    check("to_cycles", n, 17);
    check("to_errack", m_errack, 2'b01);
    check("to_no_xferack", m_xferack, 2'b00);
    check("to_sel_low", opb_select, 1'b0);

    // timeout suppressed for 40 cycles, then a normal write ack
    sl_toutsup = 1'b1;
    set_master(0, 32'h0000_0030, 1'b0, 1'b0, 1'b1);
    wait_grant("sup_grant_wait", g);
    err_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      err_seen |= (m_errack != 2'b00);
    end
    check("sup_no_err", err_seen, 1'b0);
    check("sup_still_sel", opb_select, 1'b1);
    check("sup_wdata", opb_dbus, 32'h5A5A_0030);
    sl_xferack = 1'b1;
    sl_dbus    = 32'hDEAD_BEEF;
    tick();
    sl_xferack = 1'b0;
    sl_toutsup = 1'b0;
    m_request  = '0;
    check("sup_xferack", m_xferack, 2'b01);
    check("sup_errack", m_errack, 2'b00);
    check("sup_wr_keeps_rd", m_rddbus, 32'hB00B_0100);

    // retry to master 1 while master 0 waits: master 1 regranted first
    set_master(0, 32'h0000_0040, 1'b1, 1'b0, 1'b1);
    set_master(1, 32'h0000_1040, 1'b1, 1'b0, 1'b1);
    wait_grant("rt_grant_wait", g);
    check("rt_first", g, 2'b10);
    check("rt_abus", opb_abus, 32'h0000_1040);
    tick();
    sl_retry = 1'b1;
    sl_xferack = 1'b1;
    tick();
    sl_retry = 1'b0;
    sl_xferack = 1'b0;
    check("rt_retry", m_retry, 2'b10);
    check("rt_no_xferack", m_xferack, 2'b00);
    wait_grant("rt_regrant_wait", g);
    check("rt_regrant", g, 2'b10);
    ack_now(32'h1111_2222);
    check("rt_done_ack", m_xferack, 2'b10);

    // both masters request continuously: 0,1,0,1
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    prev = 2'b10;
    while (exp_q.size() > 0) begin
      wait_grant("alt_grant_wait", g);
      check("alt_grant", g, exp_q.pop_front());
      check("alt_not_repeat", (g == prev), 1'b0);
      prev = g;
      ack_now(32'hA000_0000);
    end

    // master 0 burst of 4 with master 1 still requesting
    set_master(0, 32'h0000_0100, 1'b0, 1'b1, 1'b1);
    wait_grant("bu_grant_wait", g);
    check("bu_grant", g, 2'b01);
    check("bu_addr0", opb_abus, 32'h0000_0100);
    acks = 0;
    for (int b = 0; b < 4; b++) begin
      tick();
      if (b == 3) m_seqaddr[0] = 1'b0;
      m_abus[31:0] = 32'h0000_0100 + 32'(4 * (b + 1));
      sl_xferack = 1'b1;
      tick();
      sl_xferack = 1'b0;
      if (m_xferack == 2'b01) acks++;
      if (b < 3) begin
        check("bu_grant_hold", m_grant, 2'b01);
        check("bu_addr", opb_abus, 32'h0000_0100 + 32'(4 * (b + 1)));
      end
    end
    m_request[0] = 1'b0;
    check("bu_acks", acks, 4);
    check("bu_released", m_grant, 2'b00);
    wait_grant("bu_m1_wait", g);
    check("bu_then_m1", g, 2'b10);
    ack_now(32'h0);
    m_request = '0;

    // asynchronous reset in WAIT, then normal service
    set_master(0, 32'h0000_0200, 1'b1, 1'b0, 1'b1);
    wait_grant("ar_grant_wait", g);
    tick();
    rst_n = 1'b0;
    #1;
    check("ar_grant", m_grant, 2'b00);
    check("ar_select", opb_select, 1'b0);
    check("ar_abus", opb_abus, 32'h0);
    check("ar_rddbus", m_rddbus, 32'h0);
    check("ar_state", dbg_state, ST_IDLE);
    m_request = '0;
    tick();
    check("ar_no_ack", m_xferack | m_errack | m_retry, 2'b00);
    tick();
    rst_n = 1'b1;
    set_master(1, 32'h0000_1300, 1'b1, 1'b0, 1'b1);
    wait_grant("ar_post_wait", g);
    check("ar_post_grant", g, 2'b10);
    ack_now(32'hC0DE_0001);
    check("ar_post_ack", m_xferack, 2'b10);
    check("ar_post_data", m_rddbus, 32'hC0DE_0001);
    m_request = '0;
    repeat (3) tick();

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/opb_dual_master_arb.md
OPB_DUAL_MASTER_ARB -- requirements
Module: opb_dual_master_arb

Interface
REQ-001 SHALL have parameter C_OPB_AWIDTH, default 32, address width.
REQ-002 SHALL have parameter C_OPB_DWIDTH, default 32, data width.
REQ-003 SHALL have parameter C_TIMEOUT, default 16, cycles before a transfer is forced to errAck.
REQ-004 Ports (name  dir  width  meaning), clock and reset first:
- OPB_Clk  in  1  single clock.
- OPB_Rst_n  in  1  reset, asynchronous, active-low.
- M_request  in  2  per-master request, bit i = master i.
- M_ABus  in  64  master addresses; master 0 = bits 0:31, master 1 = bits 32:63.
- M_BE  in  8  byte enables, 4 per master.
- M_DBus  in  64  write data, 32 per master.
- M_RNW  in  2  read-not-write, per master.
- M_seqAddr  in  2  burst continuation, per master.
- M_grant  out  2  one-hot grant.
- M_xferAck  out  2  per-master completion pulse.
- M_errAck  out  2  per-master error pulse.
- M_retry  out  2  per-master retry pulse.
- M_rdDBus  out  32  registered read data, shared.
- OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr  out  32/4/32/1/1/1  slave-side bus.
- Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup  in  32/1/1/1/1  slave response.

Function
REQ-005 SHALL implement FSM states IDLE, ADDR, WAIT, DONE.
REQ-006 IDLE: any M_request high -> ADDR next cycle. Winner is chosen round-robin; pointer favours the master not last completed. Pointer resets to master 0.
REQ-007 ADDR: assert M_grant and OPB_select, register the winner's ABus/BE/DBus/RNW/seqAddr onto OPB_*, go to WAIT. Latency request->OPB_select = 1 cycle.
REQ-008 OPB_* address/data outputs SHALL be zero whenever OPB_select is low.
REQ-009 WAIT, Sl_xferAck high: pulse M_xferAck[winner] 1 cycle, latch Sl_DBus into M_rdDBus on reads. If M_seqAddr[winner] and M_request[winner] are both high -> ADDR with the same winner and no pointer update; else -> DONE.
REQ-010 WAIT, Sl_errAck high: pulse M_errAck[winner] -> DONE.
REQ-011 WAIT, Sl_retry high: pulse M_retry[winner] -> DONE, no pointer update.
REQ-012 Simultaneous xferAck and errAck SHALL be treated as errAck. Retry with either SHALL be treated as retry.
REQ-013 Timeout counter SHALL clear on entering WAIT, increment each WAIT cycle while Sl_toutSup is low, and hold while Sl_toutSup is high.
REQ-014 When count reaches C_TIMEOUT-1 with no response: pulse M_errAck[winner] -> DONE.
REQ-015 Winner drops M_request in WAIT: deassert OPB_select, no ack pulse -> DONE.
REQ-016 DONE: OPB_select and M_grant low for 1 cycle; update pointer on xferAck/errAck/timeout; -> IDLE.
REQ-017 M_grant SHALL be one-hot or zero, and SHALL equal OPB_select replicated to the winner bit.

Reset
REQ-018 Asserting OPB_Rst_n low SHALL immediately force state IDLE, pointer 0, timeout counter 0, and all outputs 0, including mid-transfer, with no ack pulses emitted.
REQ-019 First grant possible 2 cycles after reset release.

Structure
REQ-020 State encoding and default C_TIMEOUT SHALL live in shared package opb_arb_pkg.
REQ-021 The round-robin picker SHALL be sub-module opb_rr_pick2 (2 requests + pointer in, one-hot winner out, combinational).

Verification
REQ-022 Master 0 read at 0x00000010; slave acks in cycle 3 with 0xB00B0100 -> M_xferAck[0] single pulse, M_rdDBus = 0xB00B0100, OPB_select low the next cycle.
REQ-023 Both masters request continuously -> grants alternate 0,1,0,1; no master granted twice in a row.
REQ-024 Slave silent, Sl_toutSup low, C_TIMEOUT = 16 -> M_errAck pulse in the 16th WAIT cycle. With Sl_toutSup high for 40 cycles then xferAck -> xferAck, no errAck.
REQ-025 Sl_retry to master 1 while master 0 requests -> M_retry[1] pulse; master 1 regranted before master 0.
REQ-026 Master 0 burst of 4 with seqAddr high -> 4 xferAcks, no intervening grant to master 1.
REQ-027 OPB_Rst_n low during WAIT -> outputs 0 within the same cycle; after release, a new request is served normally.
